ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage; consumes operands and the muldiv opcode latched by the ID/EX pipeline register.
- Owns the HI/LO architectural registers and executes MULT/MULTU/DIV/DIVU in 32 iterations.
- Serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall request so hazard control freezes PC, IF/ID and ID/EX while a long operation is in flight.

Parameters:
- XLEN, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  EX holds a valid, non-bubble muldiv instruction
- muldiv_op  in  4  opcode from ID/EX; encoding in package
- rs_data  in  XLEN  forwarded rs operand (dividend, multiplicand, MTHI/MTLO source)
- rt_data  in  XLEN  forwarded rt operand (divisor, multiplier)
- ex_flush  in  1  kill the EX-stage instruction
- stall_req  out  1  to hazard unit; freeze upstream stages
- busy  out  1  FSM not in IDLE
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register
- mf_data  out  XLEN  MFHI returns hi, MFLO returns lo, other ops return 0

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, counter=0, internal accumulators=0. stall_req=0, busy=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - op_valid with MULT/MULTU/DIV/DIVU: latch operands (absolute values and sign flags for signed ops), counter=0, go to BUSY.
  - stall_req=1 combinationally in this accept cycle.
- BUSY:
  - One iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - After the 32nd iteration: apply sign correction, write hi/lo at that edge, go to DONE.
  - stall_req=1.
  - Total stall = 33 cycles (accept + 32).
- DONE:
  - stall_req=0, so the instruction leaves EX at this edge.
  - Unconditionally return to IDLE. The opcode still present this cycle is the completed instruction and must not restart the unit.
- MTHI/MTLO, in IDLE with op_valid: write hi/lo from rs_data at the clock edge; no stall.
- MFHI/MFLO:
  - mf_data is combinational from the hi/lo registers.
  - When busy=1, or an operation is being accepted, stall_req=1 holds the instruction until DONE. Values are final in DONE.
- Signed multiply: 64-bit |a|*|b|, negated if the operand signs differ. {hi,lo}=product.
- Signed divide:
  - Quotient (lo) is negative iff the operand signs differ; remainder (hi) takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap).
- Divide by zero (rt_data=0), any divide op: skip iterations and go IDLE→DONE directly. lo=0xFFFFFFFF, hi=rs_data. Stall is 1 cycle.
- ex_flush:
  - Any state → IDLE next edge; hi/lo untouched; stall_req=0 in the flush cycle.
  - A flushed MTHI/MTLO does not write.
  - ex_flush has priority over op_valid.
- reset mid-operation: same as reset, hi/lo cleared; it overrides ex_flush.
- Ops other than the listed opcodes, or op_valid=0: no state change.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle 64-bit multiplier. Path is IDLE→DONE, hi/lo written on the accept edge, stall is 1 cycle. Divide is unchanged.
- Undefined: iterative 33-cycle multiply as above.

Decomposition:
- Package muldiv_pkg holds:
  - the muldiv_op encoding: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8
  - the FSM state enum
  - XLEN default
  - the divide-by-zero LO constant 0xFFFFFFFF
- One natural sub-module: muldiv_sign_fix, combinational. It computes absolute values from operands and sign flags, and negates results.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 → stall_req high exactly 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB in DONE, then IDLE with no restart.
- DIVU rs=100, rt=7 → lo=14, hi=2; DIV rs=0xFFFFFFF9 (-7), rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x12345678, rt=0 → 1-cycle stall, lo=0xFFFFFFFF, hi=0x12345678.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with ex_flush pulsed on busy cycle 10 → FSM IDLE next edge, stall_req=0, hi/lo retain prior values (preset via MTHI=0xA, MTLO=0xB).
- MULTU 6*7 immediately followed by MFLO → MFLO held by stall_req until DONE, then mf_data=42, hi=0.
- Reset asserted at busy cycle 5 of DIV → hi=lo=0, busy=0, stall_req=0 on the following cycle. Repeat with MULDIV_FAST_MUL_EN: MULT 6*7 gives a 1-cycle stall and lo=42.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcode encoding,
// FSM states, default width and the divide-by-zero LO value.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [XLEN_DEFAULT-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    // Ops that occupy the unit for more than the accept cycle.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> muldiv unit signal bundle; master is the pipeline side,
// slave is the unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = muldiv_pkg::XLEN_DEFAULT
);
    logic            op_valid;
    logic [3:0]      muldiv_op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            ex_flush;
    logic            stall_req;
    logic            busy;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mf_data;

    modport master (
        output op_valid, muldiv_op, rs_data, rt_data, ex_flush,
        input  stall_req, busy, hi, lo, mf_data
    );

    modport slave (
        input  op_valid, muldiv_op, rs_data, rt_data, ex_flush,
        output stall_req, busy, hi, lo, mf_data
    );
endinterface

// File: rtl/ex_muldiv_unit_sign_fix.sv
// Combinational sign handling: operand magnitudes and result sign flags on
// the way in, conditional two's-complement negation of results on the way out.
module muldiv_sign_fix #(
    parameter int XLEN = muldiv_pkg::XLEN_DEFAULT
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              signed_op,
    output logic [XLEN-1:0]   abs_a,
    output logic [XLEN-1:0]   abs_b,
    output logic              neg_res,
    output logic              neg_rem,
    input  logic [2*XLEN-1:0] prod_in,
    input  logic              prod_neg,
    output logic [2*XLEN-1:0] prod_out,
    input  logic [XLEN-1:0]   quot_in,
    input  logic [XLEN-1:0]   rem_in,
    input  logic              quot_neg,
    input  logic              rem_neg,
    output logic [XLEN-1:0]   quot_out,
    output logic [XLEN-1:0]   rem_out
);
    logic sign_a;
    logic sign_b;

    assign sign_a = signed_op & a[XLEN-1];
    assign sign_b = signed_op & b[XLEN-1];

    // The magnitude of the most negative value is still representable unsigned.
    assign abs_a   = sign_a ? -a : a;
    assign abs_b   = sign_b ? -b : b;
    assign neg_res = sign_a ^ sign_b;
    assign neg_rem = sign_a;

    assign prod_out = prod_neg ? -prod_in : prod_in;
    assign quot_out = quot_neg ? -quot_in : quot_in;
    assign rem_out  = rem_neg  ? -rem_in  : rem_in;
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MFHI/MFLO/MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier (divide stays iterative).
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          reset,
    ex_muldiv_unit_if.slave bus
);
    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mq_q, mq_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_div_q, is_div_d;
    logic            stall;

    muldiv_op_e op;
    logic       signed_op;
    assign op        = muldiv_op_e'(bus.muldiv_op);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);

    // acc:mq is the 2*XLEN shift register; mq holds multiplier/dividend going in
    // and low product/quotient coming out.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] it_acc, it_mq;

    assign mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q, mq_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[XLEN-1:0] - opb_q;
    assign it_acc    = is_div_q ? (div_ge ? div_diff : div_shift[XLEN-1:0]) : mul_sum[XLEN:1];
    assign it_mq     = is_div_q ? {mq_q[XLEN-2:0], div_ge} : {mul_sum[0], mq_q[XLEN-1:1]};

    logic [XLEN-1:0]   abs_a, abs_b, quot_fix, rem_fix;
    logic              sf_neg_res, sf_neg_rem, prod_neg_sel;
    logic [2*XLEN-1:0] prod_sel, prod_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod    = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
    assign prod_sel     = (state_q == ST_IDLE) ? fast_prod : {it_acc, it_mq};
    assign prod_neg_sel = (state_q == ST_IDLE) ? sf_neg_res : neg_res_q;
`else
    assign prod_sel     = {it_acc, it_mq};
    assign prod_neg_sel = neg_res_q;
`endif

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .a        (bus.rs_data),
        .b        (bus.rt_data),
        .signed_op(signed_op),
        .abs_a    (abs_a),
        .abs_b    (abs_b),
        .neg_res  (sf_neg_res),
        .neg_rem  (sf_neg_rem),
        .prod_in  (prod_sel),
        .prod_neg (prod_neg_sel),
        .prod_out (prod_fix),
        .quot_in  (it_mq),
        .rem_in   (it_acc),
        .quot_neg (neg_res_q),
        .rem_neg  (neg_rem_q),
        .quot_out (quot_fix),
        .rem_out  (rem_fix)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                            {hi_d, lo_d} = prod_fix;
                            state_d      = ST_DONE;
`else
                            acc_d     = '0;
                            mq_d      = abs_b;
                            opb_d     = abs_a;
                            neg_res_d = sf_neg_res;
                            neg_rem_d = 1'b0;
                            is_div_d  = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_BUSY;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.rt_data == '0) begin
                                lo_d    = XLEN'(DIV_ZERO_LO);
                                hi_d    = bus.rs_data;
                                state_d = ST_DONE;
                            end else begin
                                acc_d     = '0;
                                mq_d      = abs_a;
                                opb_d     = abs_b;
                                neg_res_d = sf_neg_res;
                                neg_rem_d = sf_neg_rem;
                                is_div_d  = 1'b1;
                                cnt_d     = '0;
                                state_d   = ST_BUSY;
                            end
                        end
                        OP_MTHI: hi_d = bus.rs_data;
                        OP_MTLO: lo_d = bus.rs_data;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                acc_d = it_acc;
                mq_d  = it_mq;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    if (is_div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    state_d = ST_DONE;
                end
            end
            // DONE always retires; the opcode still on the bus is the finished one.
            default: state_d = ST_IDLE;
        endcase
        if (bus.ex_flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_IDLE: stall = bus.op_valid && is_long_op(bus.muldiv_op);
            ST_BUSY: stall = 1'b1;
            default: stall = 1'b0;
        endcase
        if (bus.ex_flush) stall = 1'b0;
    end

    always_comb begin
        case (op)
            OP_MFHI: bus.mf_data = hi_q;
            OP_MFLO: bus.mf_data = lo_q;
            default: bus.mf_data = '0;
        endcase
    end

    assign bus.stall_req = stall;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: latency/result model checked every cycle, directed
// cases with literal results, then randomized instruction streams.
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

    logic clk = 1'b0;
    logic reset;
    ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();
    ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: cycles left in a long op, a one-cycle "result ready" flag, HI/LO.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_long(input logic [3:0] op);
        return op == MULT || op == MULTU || op == DIV || op == DIVU;
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MULT:  return 64'(sa * sb);
            MULTU: return {32'h0, a} * {32'h0, b};
            DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic exp_stall();
        if (bus.ex_flush || m_done) return 1'b0;
        if (m_left > 0) return 1'b1;
        return bus.op_valid && is_long(bus.muldiv_op);
    endfunction

    function automatic logic [31:0] exp_mf();
        if (bus.muldiv_op == MFHI) return m_hi;
        if (bus.muldiv_op == MFLO) return m_lo;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        chk_en <= 1'b1;
        if (reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (bus.ex_flush) begin
            m_left <= 0;
            m_done <= 1'b0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi   <= p_hi;
                m_lo   <= p_lo;
                m_done <= 1'b1;
            end
        end else if (bus.op_valid) begin
            if (is_long(bus.muldiv_op)) begin
                if ((FAST && (bus.muldiv_op == MULT || bus.muldiv_op == MULTU)) ||
                    ((bus.muldiv_op == DIV || bus.muldiv_op == DIVU) && bus.rt_data == 32'h0)) begin
                    {m_hi, m_lo} <= ref_result(bus.muldiv_op, bus.rs_data, bus.rt_data);
                    m_done       <= 1'b1;
                end else begin
                    {p_hi, p_lo} <= ref_result(bus.muldiv_op, bus.rs_data, bus.rt_data);
                    m_left       <= 32;
                end
            end else if (bus.muldiv_op == MTHI) begin
                m_hi <= bus.rs_data;
            end else if (bus.muldiv_op == MTLO) begin
                m_lo <= bus.rs_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall_req", 64'(bus.stall_req), 64'(exp_stall()));
            check("busy", 64'(bus.busy), 64'((m_left > 0) || m_done));
            check("hi", 64'(bus.hi), 64'(m_hi));
            check("lo", 64'(bus.lo), 64'(m_lo));
            check("mf_data", 64'(bus.mf_data), 64'(exp_mf()));
        end
    end

    // Hold an instruction in EX until the unit stops stalling it, like the pipeline.
    task automatic run_instr(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input int flush_at, input int rst_at, output int stalls);
        logic st;
        stalls = 0;
        bus.op_valid  = 1'b1;
        bus.muldiv_op = op;
        bus.rs_data   = rs;
        bus.rt_data   = rt;
        for (int k = 0; k < 100; k++) begin
            bus.ex_flush = (k == flush_at);
            reset        = (k == rst_at);
            @(negedge clk);
            st = bus.stall_req;
            if (st) stalls++;
            @(posedge clk);
            #1;
            bus.ex_flush = 1'b0;
            if (k == rst_at || !st) begin
                reset         = 1'b0;
                bus.op_valid  = 1'b0;
                bus.muldiv_op = NOP;
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: op %0d still stalled after 100 cycles", op);
        bus.op_valid  = 1'b0;
        bus.muldiv_op = NOP;
    endtask

    task automatic idle(input int n);
        bus.op_valid  = 1'b0;
        bus.muldiv_op = NOP;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    int s;

    initial begin
        reset = 1'b1;
        bus.op_valid = 1'b0; bus.muldiv_op = NOP; bus.rs_data = '0; bus.rt_data = '0; bus.ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_hi", 64'(bus.hi), 64'h0);
        check("rst_lo", 64'(bus.lo), 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_stall", 64'(bus.stall_req), 64'h0);
        @(posedge clk); #1;

        run_instr(MULT, 32'hFFFF_FFFD, 32'd7, -1, -1, s);
        check("mult_stalls", 64'(s), FAST ? 64'd1 : 64'd33);
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        check("model_mult", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);
        check("mult_no_restart", 64'(bus.busy), 64'h0);
        @(posedge clk); #1;

        run_instr(DIVU, 32'd100, 32'd7, -1, -1, s);
        check("divu_stalls", 64'(s), 64'd33);
        check("divu_res", {bus.hi, bus.lo}, {32'd2, 32'd14});
        run_instr(DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, s);
        check("div_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_div", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_instr(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, s);
        check("div_wrap", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        check("model_wrap", {m_hi, m_lo}, 64'h0000_0000_8000_0000);

        run_instr(DIV, 32'h1234_5678, 32'd0, -1, -1, s);
        check("div0_stalls", 64'(s), 64'd1);
        check("div0_res", {bus.hi, bus.lo}, 64'h1234_5678_FFFF_FFFF);

        run_instr(MTHI, 32'hA, 32'd0, -1, -1, s);
        check("mthi_stalls", 64'(s), 64'd0);
        run_instr(MTLO, 32'hB, 32'd0, -1, -1, s);
        run_instr(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, -1, s);
        check("flush_stalls", 64'(s), FAST ? 64'd1 : 64'd10);
        check("flush_hilo", {bus.hi, bus.lo}, FAST ? 64'hFFFF_FFFE_0000_0001 : 64'h0000_000A_0000_000B);
        @(negedge clk);
        check("flush_busy", 64'(bus.busy), 64'h0);
        @(posedge clk); #1;

        run_instr(MTLO, 32'hDEAD_BEEF, 32'd0, 0, -1, s);
        check("flushed_mtlo", 64'(bus.lo), FAST ? 64'h0000_0001 : 64'h0000_000B);

        run_instr(MULTU, 32'd6, 32'd7, -1, -1, s);
        bus.op_valid = 1'b1; bus.muldiv_op = MFLO;
        @(negedge clk);
        check("mflo_data", 64'(bus.mf_data), 64'd42);
        check("mflo_hi", 64'(bus.hi), 64'd0);
        check("mflo_stall", 64'(bus.stall_req), 64'd0);
        @(posedge clk); #1;

        run_instr(DIV, 32'd100, 32'd3, -1, 5, s);
        @(negedge clk);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
        check("rst_mid_busy", 64'(bus.busy), 64'h0);
        check("rst_mid_stall", 64'(bus.stall_req), 64'h0);
        @(posedge clk); #1;

        run_instr(MULT, 32'd6, 32'd7, -1, -1, s);
        check("mult67_stalls", 64'(s), FAST ? 64'd1 : 64'd33);
        check("mult67_lo", 64'(bus.lo), 64'd42);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            int          fl;
            if ($urandom_range(0, 9) == 0) begin
                idle(1);
            end else begin
                op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                a  = rnd_val();
                b  = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_val();
                fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 35)) : -1;
                run_instr(op, a, b, fl, -1, s);
            end
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
